mdu_iter: RTL

- Iterative RV64M multiply/divide unit at the consuming end of the EXU operand interface.
- Accepts the operand pair (alu_A/alu_B) plus an M-extension opcode through a valid/ready handshake.
- Computes the result over multiple cycles and holds it in an output register until writeback takes it.
- Sits beside the single-cycle ALU; the pipeline stalls issue while in_ready_o is low.

---
 rtl/mdu_iter_if.sv | 25 ++
 rtl/mdu_iter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter_if.sv
// Operand/result handshake bundle between the EXU issue stage and the iterative
// multiply/divide unit; the unit connects through the slave modport.
interface mdu_iter_if #(
   parameter int DATA_WIDTH = 64
) ();
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [2:0]            op_i;
   logic                  word_i;
   logic [DATA_WIDTH-1:0] alu_A_i;
   logic [DATA_WIDTH-1:0] alu_B_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DATA_WIDTH-1:0] result_o;

   modport master (
      output in_valid_i, op_i, word_i, alu_A_i, alu_B_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o
   );

   modport slave (
      input  in_valid_i, op_i, word_i, alu_A_i, alu_B_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o
   );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one step per cycle, result held until taken.
module mdu_iter #(
   parameter int DATA_WIDTH = 64
) (
   input logic        clk_i,
   input logic        rst_n_i,
   input logic        flush_i,
   mdu_iter_if.slave  bus
);

   localparam int N  = DATA_WIDTH;
   localparam int H  = DATA_WIDTH / 2;
   localparam int CW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_t;

   function automatic logic [N-1:0] sext_w(input logic [H-1:0] x);
      return {{H{x[H-1]}}, x};
   endfunction

   state_t          state_q, state_d;
   op_t             op_q;
   logic            word_q;
   logic            neg_q;
   logic [CW-1:0]   cnt_q;
   logic [N-1:0]    hi_q, lo_q, opnd_q;
   logic [N-1:0]    result_q;

   logic            accept, last_step;
   logic            in_ready, out_valid;

   // Accept-time operand decode
   op_t             op_eff;
   logic            is_div, a_signed, b_signed, a_neg, b_neg, neg_d;
   logic [N-1:0]    a_ext, b_ext, a_mag, b_mag, min_val;
   logic            div_zero, div_ovf, special;
   logic [N-1:0]    special_raw, special_res, lo_init, opnd_init;

   always_comb begin
      op_eff = op_t'(bus.op_i);
      // Any multiply-high opcode with word_i degenerates to MULW.
      if (bus.word_i && (op_eff inside {OP_MULH, OP_MULHSU, OP_MULHU})) op_eff = OP_MUL;
      is_div   = op_eff[2];
      a_signed = op_eff inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      b_signed = op_eff inside {OP_MULH, OP_DIV, OP_REM};

      if (bus.word_i) begin
         a_ext   = a_signed ? sext_w(bus.alu_A_i[H-1:0]) : {{H{1'b0}}, bus.alu_A_i[H-1:0]};
         b_ext   = b_signed ? sext_w(bus.alu_B_i[H-1:0]) : {{H{1'b0}}, bus.alu_B_i[H-1:0]};
         min_val = {{(H+1){1'b1}}, {(H-1){1'b0}}};
      end else begin
         a_ext   = bus.alu_A_i;
         b_ext   = bus.alu_B_i;
         min_val = {1'b1, {(N-1){1'b0}}};
      end

      a_neg = a_signed && a_ext[N-1];
      b_neg = b_signed && b_ext[N-1];
      a_mag = a_neg ? -a_ext : a_ext;
      b_mag = b_neg ? -b_ext : b_ext;
      neg_d = (op_eff == OP_REM) ? a_neg : (a_neg ^ b_neg);

      div_zero = is_div && (b_ext == '0);
      div_ovf  = is_div && a_signed && (a_ext == min_val) && (&b_ext);
      special  = div_zero || div_ovf;

      if (op_eff[1]) special_raw = div_zero ? a_ext : '0;
      else           special_raw = div_zero ? '1 : a_ext;
      special_res = bus.word_i ? sext_w(special_raw[H-1:0]) : special_raw;

      // A word dividend is pre-shifted so its MSB is the first bit consumed.
      if (is_div) lo_init = bus.word_i ? {a_mag[H-1:0], {H{1'b0}}} : a_mag;
      else        lo_init = b_mag;
      opnd_init = is_div ? b_mag : a_mag;
   end

   // One radix-2 step plus sign correction of the would-be final value
   logic [N:0]      mul_sum, div_shift, div_diff;
   logic            div_ge;
   logic [N-1:0]    hi_n, lo_n;
   logic [2*N-1:0]  prod, prod_s;
   logic [N-1:0]    div_raw, final_res;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[N-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = !div_diff[N];

      if (op_q[2]) begin
         hi_n = div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
         lo_n = {lo_q[N-2:0], div_ge};
      end else begin
         hi_n = mul_sum[N:1];
         lo_n = {mul_sum[0], lo_q[N-1:1]};
      end

      prod   = {hi_n, lo_n};
      prod_s = neg_q ? -prod : prod;
      if (op_q[1]) div_raw = neg_q ? -hi_n : hi_n;
      else         div_raw = neg_q ? -lo_n : lo_n;

      if (op_q[2])      final_res = word_q ? sext_w(div_raw[H-1:0]) : div_raw;
      // A W product ends H positions higher in lo than a full-width one.
      else if (word_q)  final_res = sext_w(lo_n[N-1:H]);
      else if (op_q == OP_MUL) final_res = prod_s[N-1:0];
      else              final_res = prod_s[2*N-1:N];
   end

   // NOTE: every signal driven here gets a default first so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last_step = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            accept   = bus.in_valid_i && !flush_i;
            if (accept) state_d = special ? DONE : BUSY;
         end
         BUSY: begin
            last_step = (cnt_q == CW'(1));
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q    <= '0;
         result_q <= '0;
      end else if (accept) begin
         cnt_q <= bus.word_i ? CW'(H) : CW'(N);
         if (special) result_q <= special_res;
      end else if (state_q == BUSY && !flush_i) begin
         cnt_q <= cnt_q - CW'(1);
         if (last_step) result_q <= final_res;
      end
   end

   // NOTE: working registers carry no reset; they are fully loaded on every
   // accept and never observed before that.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q   <= op_eff;
         word_q <= bus.word_i;
         neg_q  <= neg_d;
         hi_q   <= '0;
         lo_q   <= lo_init;
         opnd_q <= opnd_init;
      end else if (state_q == BUSY) begin
         hi_q <= hi_n;
         lo_q <= lo_n;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.result_o    = result_q;

endmodule
